npu_act_feeder: RTL and testbench
=================================

NPU_ACT_FEEDER -- requirements
Module: npu_act_feeder

Interface
REQ-001 SHALL have parameters: ARRAY_N, default 16, systolic rows / activation banks; ADDR_WIDTH, default 32, buffer address width; DWidth, default 8, activation element width.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have `clk_i  in  1` as the single clock; all logic on rising edge.
REQ-004 SHALL have `rst_i  in  1` as the synchronous, active-high reset.
REQ-005 SHALL have `a_buf_on  in  1` as the start request from the controller; only its rising edge is used.
REQ-006 SHALL have `a_base_addr  in  ADDR_WIDTH` as the first bank row address.
REQ-007 SHALL have `a_num_rows  in  $clog2(ARRAY_N)+1` as the active row count M.
REQ-008 SHALL have `k_len  in  32` as the reduction length K, i.e. words per bank.
REQ-009 SHALL have `a_ram_r_en  out  1` as the read enable, common to all banks.
REQ-010 SHALL have `a_ram_r_addr  out  ADDR_WIDTH` as the read address, common to all banks.
REQ-011 SHALL have `a_ram_r_data  in  ARRAY_N*DWidth` as bank data; lane r = bits [r*DWidth +: DWidth]; RAM read latency 1 cycle.
REQ-012 SHALL have `sa_act_o  out  ARRAY_N*DWidth` as the skewed activations to the systolic-array west edge.
REQ-013 SHALL have `sa_act_valid_o  out  ARRAY_N` as the per-lane valid.
REQ-014 SHALL have `busy_o  out  1` as high in any non-IDLE state.
REQ-015 SHALL have `done_o  out  1` as a one-cycle completion pulse.
REQ-016 SHALL have `busy_cycles_o  out  32` as the performance counter (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, READ, FLUSH, DONE.
REQ-018 Start event: in IDLE, a_buf_on=1 while the registered previous a_buf_on=0; call this cycle 0. On start SHALL latch base, M and K, and clamp M>ARRAY_N to ARRAY_N.
REQ-019 IDLE->READ on start with K>0; IDLE->DONE on start with K==0, with no read issued.
REQ-020 READ, cycles 1..K: a_ram_r_en=1; a_ram_r_addr=base+i in cycle i+1, i=0..K-1, addition modulo 2^ADDR_WIDTH. READ->FLUSH after the K-th read.
REQ-021 FLUSH SHALL last exactly ARRAY_N cycles (K+1..K+ARRAY_N) with a_ram_r_en=0, then go to DONE.
REQ-022 DONE SHALL last one cycle (K+ARRAY_N+1), assert done_o=1, then go to IDLE.
REQ-023 Skew: the word read at address base+i on lane r SHALL appear on sa_act_o lane r in cycle i+2+r; sa_act_valid_o[r]=1 exactly in cycles r+2..r+K+1.
REQ-024 Lanes r>=M SHALL drive 0 with valid 0 for the whole operation; M==0 runs full timing with all lanes zero.
REQ-025 Outside valid windows, lanes SHALL drive 0.
REQ-026 Rising edges of a_buf_on while not IDLE SHALL be ignored.
REQ-027 A held-high a_buf_on after DONE SHALL NOT restart; a new rising edge is required.
REQ-028 Input changes on a_base_addr, a_num_rows or k_len after cycle 0 SHALL NOT affect the running operation.

Reset
REQ-029 On rst_i=1 at a clock edge: state IDLE; a_ram_r_en=0; a_ram_r_addr=0; sa_act_o=0; sa_act_valid_o=0; busy_o=0; done_o=0; busy_cycles_o=0; all skew registers and the edge-detect register cleared.
REQ-030 Reset mid-operation SHALL abort with no done_o; if a_buf_on is still high after reset release, the edge detector SHALL see previous=0 and start again.

Configuration
REQ-031 Macro NPU_ACT_FEEDER_PERF_CNT_EN defined: busy_cycles_o clears on start and increments every non-IDLE cycle, saturating at 2^32-1; it holds its value in IDLE.
REQ-032 Macro undefined: busy_cycles_o SHALL be tied to 0 and no counter logic SHALL be present.

Structure
REQ-033 Package pkg_npu SHALL hold the feeder state enum typedef, ARRAY_N default and the RAM read-latency constant (1).
REQ-034 Sub-module npu_skew_line (parameters DEPTH, DWidth; data+valid delay line) SHALL be instantiated once per lane with DEPTH=r.

Verification
REQ-035 M=16, K=4, base=0x10, rising a_buf_on -> addr 0x10..0x13 in cycles 1..4; lane0 valid 2..5; lane15 valid 17..20; done_o in cycle 21.
REQ-036 M=5, K=3 -> lanes 5..15 data 0, valid 0 throughout; lane4 valid in cycles 6..8.
REQ-037 K=0 -> no a_ram_r_en, done_o in cycle 1, busy_o high only in cycle 1.
REQ-038 rst_i=1 in cycle 3 of a K=8 run -> next cycle all outputs 0, no done_o; a_buf_on still high -> restart with cycle 0 at the first cycle after rst_i deasserts.
REQ-039 a_buf_on held high for 40 cycles, K=4 -> exactly one operation and one done_o pulse.
REQ-040 With NPU_ACT_FEEDER_PERF_CNT_EN, M=16, K=4 -> busy_cycles_o=21 after done_o; without the macro -> busy_cycles_o=0.

Source files
------------

// File: rtl/pkg_npu.sv
// Shared types and constants for the NPU activation feeder.
package pkg_npu;

    localparam int ARRAY_N_DEF = 16;
    localparam int RAM_RD_LAT  = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_FLUSH,
        ST_DONE
    } feeder_state_e;

endpackage

// File: rtl/npu_skew_line.sv
// Fixed-depth data+valid delay line for one systolic lane; data is zeroed outside valid.
// Latency: DEPTH cycles (DEPTH=0 is a pass-through).
// Backpressure: none, the line always shifts.
module npu_skew_line #(
    parameter int DEPTH  = 0,
    parameter int DWidth = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              vld_i,
    input  logic [DWidth-1:0] dat_i,
    output logic              vld_o,
    output logic [DWidth-1:0] dat_o
);

    if (DEPTH == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i | rst_i;
        assign vld_o = vld_i;
        assign dat_o = vld_i ? dat_i : '0;
    end else begin : g_delay
        logic [DEPTH*DWidth-1:0] dat_sr;
        logic [DEPTH-1:0]        vld_sr;

        // Oldest stage sits at the top of each packed shift register.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                dat_sr <= '0;
                vld_sr <= '0;
            end else begin
                dat_sr <= (DEPTH*DWidth)'({dat_sr, dat_i});
                vld_sr <= DEPTH'({vld_sr, vld_i});
            end
        end

        assign vld_o = vld_sr[DEPTH-1];
        assign dat_o = vld_sr[DEPTH-1] ? dat_sr[(DEPTH-1)*DWidth +: DWidth] : '0;
    end

endmodule

// File: rtl/npu_act_feeder.sv
// Streams K words from ARRAY_N activation banks and skews lane r by r cycles into the array.
// Latency: first read 1 cycle after a_buf_on rises, lane r data at i+2+r; done after K+ARRAY_N+1.
// Backpressure: none; optional busy-cycle counter under NPU_ACT_FEEDER_PERF_CNT_EN.
module npu_act_feeder
    import pkg_npu::*;
#(
    parameter int ARRAY_N    = ARRAY_N_DEF,
    parameter int ADDR_WIDTH = 32,
    parameter int DWidth     = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        a_buf_on,
    input  logic [ADDR_WIDTH-1:0]       a_base_addr,
    input  logic [$clog2(ARRAY_N):0]    a_num_rows,
    input  logic [31:0]                 k_len,
    output logic                        a_ram_r_en,
    output logic [ADDR_WIDTH-1:0]       a_ram_r_addr,
    input  logic [ARRAY_N*DWidth-1:0]   a_ram_r_data,
    output logic [ARRAY_N*DWidth-1:0]   sa_act_o,
    output logic [ARRAY_N-1:0]          sa_act_valid_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [31:0]                 busy_cycles_o
);

    localparam int MW = $clog2(ARRAY_N) + 1;

    feeder_state_e         state_q, state_d;
    logic [31:0]           cnt_q, cnt_d;
    logic [31:0]           k_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [MW-1:0]         m_q;
    logic                  buf_on_q;
    logic                  start;
    logic                  rd_en;
    logic [RAM_RD_LAT-1:0] rd_vld_sr;
    logic                  rd_vld;

    assign start = (state_q == ST_IDLE) && a_buf_on && !buf_on_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            k_q       <= '0;
            base_q    <= '0;
            m_q       <= '0;
            buf_on_q  <= 1'b0;
            rd_vld_sr <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            buf_on_q  <= a_buf_on;
            rd_vld_sr <= RAM_RD_LAT'({rd_vld_sr, rd_en});
            if (start) begin
                base_q <= a_base_addr;
                k_q    <= k_len;
                m_q    <= (32'(a_num_rows) > 32'(ARRAY_N)) ? MW'(ARRAY_N) : a_num_rows;
            end
        end
    end

    // cnt_q indexes reads in READ and drain cycles in FLUSH.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (k_len == '0) ? ST_DONE : ST_READ;
                    cnt_d   = '0;
                end
            end
            ST_READ: begin
                rd_en = 1'b1;
                if (cnt_q == k_q - 32'd1) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == 32'(ARRAY_N - 1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign a_ram_r_en   = rd_en;
    assign a_ram_r_addr = rd_en ? base_q + ADDR_WIDTH'(cnt_q) : '0;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);
    assign rd_vld       = rd_vld_sr[RAM_RD_LAT-1];

    for (genvar r = 0; r < ARRAY_N; r++) begin : g_lane
        logic lane_vld;
        assign lane_vld = rd_vld && (32'(m_q) > 32'(r));

        npu_skew_line #(
            .DEPTH  (r),
            .DWidth (DWidth)
        ) u_skew (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .vld_i  (lane_vld),
            .dat_i  (lane_vld ? a_ram_r_data[r*DWidth +: DWidth] : '0),
            .vld_o  (sa_act_valid_o[r]),
            .dat_o  (sa_act_o[r*DWidth +: DWidth])
        );
    end

`ifdef NPU_ACT_FEEDER_PERF_CNT_EN
    logic [31:0] busy_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_cnt_q <= '0;
        end else if (start) begin
            busy_cnt_q <= '0;
        end else if ((state_q != ST_IDLE) && (busy_cnt_q != '1)) begin
            busy_cnt_q <= busy_cnt_q + 32'd1;
        end
    end

    assign busy_cycles_o = busy_cnt_q;
`else
    assign busy_cycles_o = '0;
`endif

endmodule

// File: tb/tb_npu_act_feeder.sv
// Directed table-driven bench for npu_act_feeder with a 1-cycle-latency bank RAM model.
module tb_npu_act_feeder;

    localparam int N  = 16;
    localparam int AW = 32;
    localparam int DW = 8;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            a_buf_on = 1'b0;
    logic [AW-1:0]   a_base_addr = '0;
    logic [4:0]      a_num_rows = '0;
    logic [31:0]     k_len = '0;
    logic            a_ram_r_en;
    logic [AW-1:0]   a_ram_r_addr;
    logic [N*DW-1:0] a_ram_r_data = '0;
    logic [N*DW-1:0] sa_act_o;
    logic [N-1:0]    sa_act_valid_o;
    logic            busy_o;
    logic            done_o;
    logic [31:0]     busy_cycles_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    npu_act_feeder #(.ARRAY_N(N), .ADDR_WIDTH(AW), .DWidth(DW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .a_buf_on       (a_buf_on),
        .a_base_addr    (a_base_addr),
        .a_num_rows     (a_num_rows),
        .k_len          (k_len),
        .a_ram_r_en     (a_ram_r_en),
        .a_ram_r_addr   (a_ram_r_addr),
        .a_ram_r_data   (a_ram_r_data),
        .sa_act_o       (sa_act_o),
        .sa_act_valid_o (sa_act_valid_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .busy_cycles_o  (busy_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] pat(logic [31:0] a, int r);
        return a[7:0] ^ a[15:8] ^ 8'(r * 37 + 1);
    endfunction

    // Bank RAM: every lane returns a distinct pattern of the address one cycle later.
    always @(posedge clk_i) begin
        for (int r = 0; r < N; r++) a_ram_r_data[r*DW +: DW] <= pat(a_ram_r_addr, r);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    typedef struct {
        string       name;
        int          m;
        int          k;
        logic [31:0] base;
        int          exp_done;
        int          exp_rd;
        int          exp_l0;
        int          exp_l15;
        bit          poke;
    } vec_t;

    task automatic start_op(input int m, input int k, input logic [31:0] base);
        @(posedge clk_i); #1;
        a_num_rows  = 5'(m);
        k_len       = 32'(k);
        a_base_addr = base;
        a_buf_on    = 1'b1;
    endtask

    // Checks every cycle from 1 to done+1 against the expected feeder timing.
    task automatic run_check(input vec_t v);
        int          meff, err, rd, l0, l15, dcyc, dcnt;
        bit          exp_v;
        logic [7:0]  exp_d;
        meff = (v.m > N) ? N : v.m;
        err = 0; rd = 0; l0 = 0; l15 = 0; dcyc = -1; dcnt = 0;
        for (int c = 1; c <= v.exp_done + 1; c++) begin
            @(posedge clk_i); #1;
            if (a_ram_r_en) rd++;
            if (a_ram_r_en !== (c <= v.k)) err++;
            if (c <= v.k && a_ram_r_addr !== v.base + 32'(c - 1)) err++;
            if (busy_o !== (c <= v.exp_done)) err++;
            if (done_o) begin
                dcnt++;
                if (dcyc < 0) dcyc = c;
            end
            if (sa_act_valid_o[0]) l0++;
            if (sa_act_valid_o[N-1]) l15++;
            for (int r = 0; r < N; r++) begin
                exp_v = (r < meff) && (c >= r + 2) && (c <= r + v.k + 1);
                exp_d = exp_v ? pat(v.base + 32'(c - 2 - r), r) : 8'h00;
                if (sa_act_valid_o[r] !== exp_v) err++;
                if (sa_act_o[r*DW +: DW] !== exp_d) err++;
            end
            if (c == 1) begin
                a_buf_on    = 1'b0;
                a_base_addr = ~v.base;
                a_num_rows  = 5'd3;
                k_len       = 32'd50;
            end
            if (v.poke && c == 3) a_buf_on = 1'b1;
            if (v.poke && c == 4) a_buf_on = 1'b0;
        end
        check({v.name, "_done_cycle"}, 64'(dcyc), 64'(v.exp_done));
        check({v.name, "_done_pulses"}, 64'(dcnt), 64'd1);
        check({v.name, "_reads"}, 64'(rd), 64'(v.exp_rd));
        check({v.name, "_lane0_vld"}, 64'(l0), 64'(v.exp_l0));
        check({v.name, "_lane15_vld"}, 64'(l15), 64'(v.exp_l15));
        check({v.name, "_cycle_errs"}, 64'(err), 64'd0);
`ifdef NPU_ACT_FEEDER_PERF_CNT_EN
        check({v.name, "_busy_cycles"}, 64'(busy_cycles_o), 64'(v.exp_done));
`else
        check({v.name, "_busy_cycles"}, 64'(busy_cycles_o), 64'd0);
`endif
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{"m16k4",   16, 4,  32'h0000_0010, 21, 4,  4,  4,  1'b1};
        vecs[1] = '{"m5k3",    5,  3,  32'h0000_0100, 20, 3,  3,  0,  1'b0};
        vecs[2] = '{"m0k2",    0,  2,  32'h0000_0040, 19, 2,  0,  0,  1'b1};
        vecs[3] = '{"m20wrap", 20, 2,  32'hFFFF_FFFF, 19, 2,  2,  2,  1'b0};
        vecs[4] = '{"m1k1",    1,  1,  32'h0000_0007, 18, 1,  1,  0,  1'b0};
        vecs[5] = '{"k0",      16, 0,  32'h0000_0033, 1,  0,  0,  0,  1'b0};
        vecs[6] = '{"m16k16",  16, 16, 32'h0000_00A0, 33, 16, 16, 16, 1'b1};

        repeat (3) @(posedge clk_i);
        #1;
        check("rst_r_en",  64'(a_ram_r_en), 64'd0);
        check("rst_addr",  64'(a_ram_r_addr), 64'd0);
        check("rst_act",   64'(|sa_act_o), 64'd0);
        check("rst_vld",   64'(sa_act_valid_o), 64'd0);
        check("rst_busy",  64'(busy_o), 64'd0);
        check("rst_done",  64'(done_o), 64'd0);
        check("rst_bcyc",  64'(busy_cycles_o), 64'd0);
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);

        for (int i = 0; i < 7; i++) begin
            start_op(vecs[i].m, vecs[i].k, vecs[i].base);
            run_check(vecs[i]);
            repeat (2) @(posedge clk_i);
        end

        // Reset during cycle 3 of a K=8 run, a_buf_on left high.
        begin
            int dseen;
            dseen = 0;
            start_op(16, 8, 32'h20);
            for (int c = 1; c <= 3; c++) begin
                @(posedge clk_i); #1;
                if (done_o) dseen++;
            end
            rst_i = 1'b1;
            @(posedge clk_i); #1;
            if (done_o) dseen++;
            check("midrst_r_en", 64'(a_ram_r_en), 64'd0);
            check("midrst_act",  64'(|sa_act_o), 64'd0);
            check("midrst_vld",  64'(sa_act_valid_o), 64'd0);
            check("midrst_busy", 64'(busy_o), 64'd0);
            check("midrst_bcyc", 64'(busy_cycles_o), 64'd0);
            check("midrst_no_done", 64'(dseen), 64'd0);
            rst_i = 1'b0;
            run_check('{"restart", 16, 8, 32'h20, 25, 8, 8, 8, 1'b0});
            repeat (2) @(posedge clk_i);
        end

        // a_buf_on held high for 40 cycles: one operation only.
        begin
            int rd, dn;
            rd = 0; dn = 0;
            start_op(2, 4, 32'h55);
            for (int c = 1; c <= 40; c++) begin
                @(posedge clk_i); #1;
                if (a_ram_r_en) rd++;
                if (done_o) dn++;
            end
            check("hold_reads", 64'(rd), 64'd4);
            check("hold_dones", 64'(dn), 64'd1);
            check("hold_idle",  64'(busy_o), 64'd0);
            a_buf_on = 1'b0;
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
